// File: rtl/shift_normalizer.sv
// Sequential 16-bit normalizer: shifts one bit per cycle toward MSB or LSB
// and emits the shifter shamt code that undoes the normalization.
module shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   shift_count,
  output logic [SHW-1:0]   restore_shamt,
  output logic             no_shift,
  output logic             zero_in
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] work;
  logic             mode_q;
  logic [SHW-1:0]   cnt;
  logic             target;
  logic [SHW-1:0]   shamt;

  assign target = mode_q ? work[0] : work[WIDTH-1];

  // mode 0 undoes with a right shift (code 32-n), mode 1 with a left (n-1)
  always_comb begin
    shamt = '0;
    if (cnt != '0) begin
      shamt = mode_q ? cnt - SHW'(1) : SHW'(0) - cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (in_data == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (target) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      work          <= '0;
      mode_q        <= 1'b0;
      cnt           <= '0;
      out_data      <= '0;
      shift_count   <= '0;
      restore_shamt <= '0;
      no_shift      <= 1'b0;
      zero_in       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work   <= in_data;
            mode_q <= mode;
            cnt    <= '0;
            if (in_data == '0) begin
              zero_in       <= 1'b1;
              out_data      <= '0;
              shift_count   <= '0;
              restore_shamt <= '0;
              no_shift      <= 1'b1;
            end else begin
              zero_in <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (target) begin
            out_data      <= work;
            shift_count   <= cnt;
            restore_shamt <= shamt;
            no_shift      <= (cnt == '0);
          end else begin
            work <= mode_q ? (work >> 1) : (work << 1);
            cnt  <= cnt + SHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: randomized requests checked
// against an arithmetic reference model and the shifter decode.
module tb_shift_normalizer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] in_data = '0;
  logic        busy;
  logic        done;
  logic [15:0] out_data;
  logic [4:0]  shift_count;
  logic [4:0]  restore_shamt;
  logic        no_shift;
  logic        zero_in;

  shift_normalizer dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .start        (start),
    .mode         (mode),
    .in_data      (in_data),
    .busy         (busy),
    .done         (done),
    .out_data     (out_data),
    .shift_count  (shift_count),
    .restore_shamt(restore_shamt),
    .no_shift     (no_shift),
    .zero_in      (zero_in)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [15:0] res;
    logic [4:0]  cnt;
    logic [4:0]  shamt;
    logic        ns;
    logic        zi;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   have_last = 0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: count positions to the first set bit in the target direction.
  function automatic exp_t model(logic [15:0] x, logic m);
    exp_t e;
    int n;
    n = 0;
    if (x != 0) begin
      if (!m) begin
        for (int b = 15; b >= 0; b--) if (x[b]) begin n = 15 - b; break; end
      end else begin
        for (int b = 0; b < 16; b++) if (x[b]) begin n = b; break; end
      end
    end
    e.data  = x;
    e.res   = m ? (x >> n) : (x << n);
    e.cnt   = 5'(n);
    e.ns    = (n == 0);
    e.zi    = (x == 0);
    e.shamt = (n == 0) ? 5'd0 : (m ? 5'(n - 1) : 5'(32 - n));
    e.cyc   = 0;
    return e;
  endfunction

  // Datapath shifter decode of the shamt code.
  function automatic logic [15:0] shifter(logic [15:0] v, logic [4:0] c);
    int amt;
    if (c < 16) begin
      amt = int'(c) + 1;
      return v << amt;
    end
    amt = 32 - int'(c);
    return v >> amt;
  endfunction

  always @(negedge CLK) begin
    if (!Reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("out_data", 32'(out_data), 32'(e.res));
        chk("shift_count", 32'(shift_count), 32'(e.cnt));
        chk("restore_shamt", 32'(restore_shamt), 32'(e.shamt));
        chk("no_shift", 32'(no_shift), 32'(e.ns));
        chk("zero_in", 32'(zero_in), 32'(e.zi));
        if (e.data != 0 && !no_shift)
          chk("restore_roundtrip", 32'(shifter(out_data, restore_shamt)),
              32'(e.data));
        last = e;
        have_last = 1;
      end
    end else if (!Reset && !busy && have_last) begin
      chk("hold", {out_data, shift_count, restore_shamt, no_shift, zero_in},
          {last.res, last.cnt, last.shamt, last.ns, last.zi});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one request; optionally poke a junk start while it is busy.
  task automatic issue(logic [15:0] d, logic m, bit junk, int junk_at);
    exp_t e;
    wait_idle();
    e = model(d, m);
    e.cyc = cyc + 1 + ((d == 0) ? 0 : int'(e.cnt) + 1);
    start = 1'b1;
    mode = m;
    in_data = d;
    q.push_back(e);
    tick();
    start = 1'b0;
    mode = $urandom_range(0, 1);
    in_data = 16'($urandom);
    if (junk) begin
      for (int i = 0; i < junk_at; i++) tick();
      if (busy) begin
        start = 1'b1;
        in_data = 16'hFFFF;
        mode = ~m;
        tick();
        start = 1'b0;
      end
    end
  endtask

  function automatic logic [15:0] rand_data();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 16'h0000;
    if (k < 4) return 16'(1) << $urandom_range(0, 15);
    return 16'($urandom);
  endfunction

  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", {out_data, shift_count, restore_shamt, no_shift, zero_in},
        32'd0);
    Reset = 1'b0;
    tick();

    issue(16'h0001, 1'b0, 0, 0);
    issue(16'h00F0, 1'b1, 0, 0);
    issue(16'h8000, 1'b0, 0, 0);
    issue(16'h0000, 1'b0, 0, 0);
    issue(16'h0000, 1'b1, 0, 0);
    issue(16'h8000, 1'b1, 0, 0);
    issue(16'h0001, 1'b1, 0, 0);
    issue(16'h0100, 1'b0, 1, 3);

    // Abort mid-operation with a one-cycle reset.
    wait_idle();
    tick();
    start = 1'b1;
    mode = 1'b0;
    in_data = 16'h0001;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    have_last = 0;
    tick();
    Reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_outs", {out_data, shift_count, restore_shamt, no_shift, zero_in},
        32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) chk("abort_no_done", 32'(done), 32'd0);
    end
    issue(16'h0001, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      int gap;
      issue(rand_data(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 6));
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) tick();
    end

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        tick();
        n++;
      end
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    end
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
